// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are active-high abcdefg: bit 6 = a ... bit 0 = g.
package seven_seg_pkg;

  typedef logic [6:0] seg7_t;

  // All segments dark (active-high encoding).
  localparam seg7_t SEG7_BLANK = 7'h00;

  // Hex glyphs 0..F, active-high abcdefg.
  localparam seg7_t SEG7_HEX [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex digit to active-high abcdefg decoder.
// Output polarity is applied by the instantiating driver.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  output seg7_t      seg
);

  assign seg = SEG7_HEX[digit];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment display driver.
// Scans NUM_DIGITS digits, one REFRESH_DIV-cycle slot each, with the
// first BLANK_CYCLES of every slot dark to avoid ghosting. Loaded data
// sits in a shadow buffer and is committed only at frame boundaries so
// a frame never mixes old and new digits. All pins are registered.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Pin levels for "off"; XOR with these converts active-high to pin polarity.
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   shadow_val;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic [4*NUM_DIGITS-1:0]   active_val;
  logic [NUM_DIGITS-1:0]     active_dp;

  logic                      frame_start;
  logic                      commit;
  logic                      lit;
  logic                      blank_cur;
  logic [3:0]                cur_digit;
  seg7_t                     dec_seg;
  seg7_t                     seg_on;
  logic                      dp_on;
  logic [NUM_DIGITS-1:0]     an_on;
  logic [NUM_DIGITS-1:0]     zero_from;

  // Frame boundary and buffer commit conditions (dark display commits every cycle).
  always_comb begin
    frame_start = en && (cnt == CNT_LAST) && (idx == IDX_LAST);
    commit      = !en || frame_start;
  end

  // Slot counter and digit index; held at zero while the scan is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!en) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Double buffer: load fills the shadow, commit copies it to the displayed copy.
  // A load landing on a commit cycle bypasses the shadow so nothing is left pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (commit) begin
        if (load) begin
          active_val <= value;
          active_dp  <= dp_in;
        end else begin
          active_val <= shadow_val;
          active_dp  <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Select the current digit and flag digits that are zero along with everything above.
  always_comb begin
    cur_digit = active_val[{idx, 2'b00} +: 4];
    zero_from = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_from[k] = ((active_val >> (4 * k)) == '0);
    end
    blank_cur = lzb && (idx != '0) && zero_from[idx];
  end

  hex_to_seg7 u_dec (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // Active-high pin intent: dark during dead time, leading zeros suppressed.
  always_comb begin
    lit    = en && (cnt >= BLANK_END);
    an_on  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_on[k] = lit && (idx == IDX_W'(k));
    end
    if (lit && !blank_cur) begin
      seg_on = dec_seg;
    end else begin
      seg_on = SEG7_BLANK;
    end
    dp_on = lit && active_dp[idx];
  end

  // Register the pins with polarity applied, plus the frame start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_on ^ SEG_OFF;
      dp         <= dp_on ^ DP_OFF;
      an         <= an_on ^ AN_OFF;
      frame_tick <= frame_start;
    end
  end

endmodule
